// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP,
// fetch FSM encoding and the fetch-to-decode packet.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: imem req/ready + rvalid on one side,
// valid/ready toward decode on the other.
interface inst_fetch_if;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  logic        i_id_ready;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ready,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    input  i_id_ready,
    output o_valid,
    output o_inst,
    output o_pc
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ready,
    output i_imem_rvalid,
    output i_imem_rdata,
    output i_id_ready,
    input  o_valid,
    input  o_inst,
    input  o_pc
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Output register plus one skid entry between fetch and decode.
// Flush drops both entries; o_inst reads NOP while empty.
module fetch_skid_buf
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  input  logic       out_ready,
  output logic       out_valid,
  output fetch_pkt_t out_pkt
);

  logic       skid_valid;
  fetch_pkt_t skid_pkt;
  logic       take;

  assign take = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pkt    <= '{inst: NOP_INST, pc: 32'h0};
      skid_valid <= 1'b0;
      skid_pkt   <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_pkt.inst <= NOP_INST;
      skid_valid   <= 1'b0;
    end else if (skid_valid) begin
      // Upstream never produces while the skid is occupied
      if (take) begin
        out_pkt    <= skid_pkt;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || take) begin
        out_valid <= 1'b1;
        out_pkt   <= in_pkt;
      end else begin
        skid_valid <= 1'b1;
        skid_pkt   <= in_pkt;
      end
    end else if (take) begin
      out_valid    <= 1'b0;
      out_pkt.inst <= NOP_INST;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding imem request FSM,
// redirect with stale-response squash, skid-buffered output.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic         i_clk,
  input  logic         i_rst,
  inst_fetch_if.master bus,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  output logic         o_misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         req;
  logic         accept;
  logic         rvalid;
  logic         take;
  logic         to_out;
  logic         out_valid;
  fetch_pkt_t   rsp_pkt;
  fetch_pkt_t   out_pkt;

  assign req     = (state == S_REQ) && !i_rst;
  assign accept  = req && bus.i_imem_ready;
  assign rvalid  = bus.i_imem_rvalid;
  assign take    = out_valid && bus.i_id_ready;
  assign to_out  = rvalid && (state == S_WAIT) && !i_redirect;
  assign rsp_pkt = '{inst: bus.i_imem_rdata, pc: req_pc};

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = pc;
  assign bus.o_valid     = out_valid;
  assign bus.o_inst      = out_pkt.inst;
  assign bus.o_pc        = out_pkt.pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      o_misalign <= 1'b0;
    end else if (i_redirect) begin
      pc <= word_align(i_redirect_pc);
      if (i_redirect_pc[1:0] != 2'b00)
        o_misalign <= 1'b1;
      // Anything in flight belongs to the old path
      unique case (state)
        S_REQ:  state <= accept ? S_DROP : S_REQ;
        S_WAIT: state <= rvalid ? S_REQ : S_DROP;
        S_HOLD: state <= S_REQ;
        S_DROP: state <= rvalid ? S_REQ : S_DROP;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (accept) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            pc    <= req_pc + 32'd4;
            state <= (!out_valid || take) ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (take)
            state <= S_REQ;
        end
        S_DROP: begin
          if (rvalid)
            state <= S_REQ;
        end
      endcase
    end
  end

  fetch_skid_buf #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_redirect),
    .in_valid  (to_out),
    .in_pkt    (rsp_pkt),
    .out_ready (bus.i_id_ready),
    .out_valid (out_valid),
    .out_pkt   (out_pkt)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table, then wrap
// and random-backpressure in-order delivery sequences.
module tb_inst_fetch;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        mis;

  int passed = 0;
  int total  = 0;

  inst_fetch_if bus();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .i_redirect    (redir),
    .i_redirect_pc (rpc),
    .o_misalign    (mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // 1-cycle latency memory, reset together with the DUT
  always @(posedge clk) begin
    if (rst) begin
      bus.i_imem_rvalid <= 1'b0;
      bus.i_imem_rdata  <= 32'h0;
    end else begin
      bus.i_imem_rvalid <= bus.o_imem_req & bus.i_imem_ready;
      bus.i_imem_rdata  <= memw(bus.o_imem_addr);
    end
  end

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        idr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  function automatic vec_t v(
    input logic r, input logic rd, input logic [31:0] rp,
    input logic rdy, input logic idr,
    input logic er, input logic [31:0] ea,
    input logic ev, input logic [31:0] ep, input logic em
  );
    vec_t x;
    x.rst = r; x.redir = rd; x.rpc = rp;
    x.ready = rdy; x.idr = idr;
    x.e_req = er; x.e_addr = ea;
    x.e_valid = ev; x.e_pc = ep; x.e_mis = em;
    return x;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n;

    // inputs: rst redir rpc ready idr | req addr valid pc mis
    tbl[0]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[1]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[2]  = v(0,0,32'h0,1,1, 1,32'h4,  1,32'h0,0);
    tbl[3]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[4]  = v(0,0,32'h0,1,1, 1,32'h8,  1,32'h4,0);
    tbl[5]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h4,0);
    tbl[6]  = v(1,0,32'h0,1,1, 1,32'hC,  1,32'h8,0);
    tbl[7]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[8]  = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[9]  = v(0,0,32'h0,1,0, 1,32'h4,  1,32'h0,0);
    tbl[10] = v(0,0,32'h0,1,0, 0,32'h0,  1,32'h0,0);
    tbl[11] = v(0,0,32'h0,1,0, 0,32'h0,  1,32'h0,0);
    tbl[12] = v(0,0,32'h0,1,0, 0,32'h0,  1,32'h0,0);
    tbl[13] = v(0,0,32'h0,1,0, 0,32'h0,  1,32'h0,0);
    tbl[14] = v(0,0,32'h0,1,0, 0,32'h0,  1,32'h0,0);
    tbl[15] = v(0,0,32'h0,1,1, 0,32'h0,  1,32'h0,0);
    tbl[16] = v(0,0,32'h0,1,1, 1,32'h8,  1,32'h4,0);
    tbl[17] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h4,0);
    tbl[18] = v(0,1,32'h100,1,1, 1,32'hC, 1,32'h8,0);
    tbl[19] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h8,0);
    tbl[20] = v(0,0,32'h0,1,1, 1,32'h100,0,32'h8,0);
    tbl[21] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h8,0);
    tbl[22] = v(0,0,32'h0,1,1, 1,32'h104,1,32'h100,0);
    tbl[23] = v(0,1,32'h200,1,1, 0,32'h0, 0,32'h100,0);
    tbl[24] = v(0,0,32'h0,1,1, 1,32'h200,0,32'h100,0);
    tbl[25] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h100,0);
    tbl[26] = v(0,1,32'h102,0,1, 1,32'h204,1,32'h200,0);
    tbl[27] = v(0,0,32'h0,1,1, 1,32'h100,0,32'h200,1);
    tbl[28] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h200,1);
    tbl[29] = v(0,0,32'h0,1,0, 1,32'h104,1,32'h100,1);
    tbl[30] = v(1,0,32'h0,1,0, 0,32'h0,  1,32'h100,1);
    tbl[31] = v(0,0,32'h0,0,1, 0,32'h0,  0,32'h0,0);
    tbl[32] = v(0,0,32'h0,1,1, 1,32'h0,  0,32'h0,0);
    tbl[33] = v(0,0,32'h0,1,1, 0,32'h0,  0,32'h0,0);
    tbl[34] = v(0,0,32'h0,0,1, 1,32'h4,  1,32'h0,0);

    bus.i_imem_ready = 1'b1;
    bus.i_id_ready   = 1'b1;
    rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("r%0d_req", i), 32'(bus.o_imem_req),
          32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("r%0d_addr", i), bus.o_imem_addr,
            tbl[i].e_addr);
      chk($sformatf("r%0d_valid", i), 32'(bus.o_valid),
          32'(tbl[i].e_valid));
      chk($sformatf("r%0d_pc", i), bus.o_pc, tbl[i].e_pc);
      chk($sformatf("r%0d_inst", i), bus.o_inst,
          tbl[i].e_valid ? memw(tbl[i].e_pc) : 32'h13);
      chk($sformatf("r%0d_mis", i), 32'(mis),
          32'(tbl[i].e_mis));
      rst              = tbl[i].rst;
      redir            = tbl[i].redir;
      rpc              = tbl[i].rpc;
      bus.i_imem_ready = tbl[i].ready;
      bus.i_id_ready   = tbl[i].idr;
      tick();
    end

    // PC wrap: 0xFFFF_FFFC fetch is followed by address 0
    redir = 1'b1;
    rpc = 32'hFFFF_FFFC;
    bus.i_imem_ready = 1'b0;
    bus.i_id_ready = 1'b1;
    tick();
    redir = 1'b0;
    chk("wrap_req", 32'(bus.o_imem_req), 32'h1);
    chk("wrap_addr0", bus.o_imem_addr, 32'hFFFF_FFFC);
    bus.i_imem_ready = 1'b1;
    tick();
    tick();
    chk("wrap_valid", 32'(bus.o_valid), 32'h1);
    chk("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", bus.o_inst, memw(32'hFFFF_FFFC));
    chk("wrap_next", bus.o_imem_addr, 32'h0);

    // Random backpressure: stream must stay strictly in order
    exp_pc = 32'hFFFF_FFFC;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      bus.i_id_ready   = 1'($urandom_range(0, 1));
      bus.i_imem_ready = ($urandom_range(0, 3) != 0);
      if (bus.o_valid && bus.i_id_ready) begin
        chk("stream_pc", bus.o_pc, exp_pc);
        chk("stream_inst", bus.o_inst, memw(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n++;
      end else if (!bus.o_valid) begin
        chk("idle_nop", bus.o_inst, 32'h13);
      end
      tick();
    end
    chk("stream_progress", 32'(n >= 40), 32'h1);
    chk("mis_after_rst", 32'(mis), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. It holds the PC and issues word requests to instruction memory over a req/ready + rvalid handshake. It presents {instruction, PC, valid} to decode with backpressure via a one-entry skid buffer, and redirects on taken jal/branch with stale-response squashing.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset
NOP_INST, 32'h0000_0013, instruction driven on o_inst whenever o_valid=0 (addi x0,x0,0)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  reset, synchronous, active-high
o_imem_req  output  1  fetch request valid
o_imem_addr  output  32  word-aligned fetch address, bits[1:0]=0
i_imem_ready  input  1  memory accepts request this cycle when req&ready
i_imem_rvalid  input  1  response valid; always accepted, never backpressured
i_imem_rdata  input  32  fetched instruction
i_redirect  input  1  taken jal/branch pulse
i_redirect_pc  input  32  redirect target
i_id_ready  input  1  decode consumes o_inst this cycle when o_valid&i_id_ready
o_valid  output  1  o_inst/o_pc valid
o_inst  output  32  instruction to decode
o_pc  output  32  PC of o_inst
o_misalign  output  1  sticky: a redirect target had bits[1:0]!=0

Behaviour:
- Reset (sync): pc=RESET_PC, state=S_REQ, o_valid=0, skid empty, o_inst=NOP_INST, o_pc=0, o_misalign=0, o_imem_req=0 during the reset cycle. The memory is reset by the same i_rst; no response is expected after reset.
- At most one outstanding request. Requests are in order, with latency >=1 cycle from accept to rvalid.
- States:
  - S_REQ: o_imem_req=1, addr=pc. On req&ready, latch req_pc=pc and go to S_WAIT.
  - S_WAIT: wait for rvalid. On rvalid, write {rdata,req_pc} to the output register if it is empty or consumed this cycle, then pc=req_pc+4 and go to S_REQ. Otherwise write it to the skid and go to S_HOLD.
  - S_HOLD: no request. When the output register is consumed, skid moves to the output register next cycle, skid empties, and the state goes to S_REQ.
  - S_DROP: a stale request is outstanding. The next rvalid is discarded and the state goes to S_REQ.
- Redirect has highest priority. Within that cycle:
  - o_valid and the skid are cleared next cycle; a same-cycle consume is irrelevant.
  - pc = {i_redirect_pc[31:2],2'b00}. If bits[1:0]!=0, set o_misalign, which clears only on reset.
  - Next state from S_REQ with request accepted this cycle: S_DROP.
  - Next state from S_REQ without acceptance: S_REQ.
  - Next state from S_WAIT with no rvalid: S_DROP.
  - Next state from S_WAIT with rvalid: S_REQ, response discarded.
  - Next state from S_HOLD: S_REQ.
  - Next state from S_DROP with no rvalid: S_DROP.
  - Next state from S_DROP with rvalid: S_REQ.
- Throughput: one instruction per two cycles at 1-cycle memory latency (req cycle + wait cycle). Instructions are never lost or duplicated under any i_id_ready pattern.
- o_inst=NOP_INST and o_pc holds its last value whenever o_valid=0.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Output register holds stable while o_valid&!i_id_ready.

Decomposition:
- Shared package rv_pkg holds:
  - the existing opcode constants
  - NOP constant 32'h0000_0013
  - fetch state encoding S_REQ/S_WAIT/S_HOLD/S_DROP (2 bits)
- One sub-module, fetch_skid_buf: output register plus one skid entry, with a flush input. The FSM and PC stay in inst_fetch.

Test Plan:
- Reset release, memory ready=1, latency 1, id_ready=1 -> addrs 0,4,8 issued; o_valid pulses every other cycle with (o_pc,o_inst) = (0,mem[0]), (4,mem[1]), (8,mem[2]).
- id_ready=0 for 6 cycles after the first valid -> output holds pc 0; skid takes pc 4; no request while in S_HOLD; after release, pc 0 then pc 4 delivered in consecutive cycles, then request 8.
- Redirect to 32'h100 in the same cycle a request is accepted -> the response for the old addr is dropped; next request addr 0x100; first valid o_pc=0x100.
- Redirect coincident with rvalid in S_WAIT -> that instruction never appears; o_valid=0 next cycle; next addr = redirect target.
- Redirect to 32'h102 -> addr 0x100 issued; o_misalign=1 stays set until i_rst.
- Assert i_rst while in S_WAIT with o_valid=1 -> next cycle o_valid=0, o_inst=NOP; after release, first request addr=RESET_PC.
